// File: rtl/data_stream_checker.sv
// Valid/ready stream sink with LFSR-driven back-pressure and incrementing-sequence checker.
// Optional: define DATA_STREAM_CHECKER_RESYNC_EN to re-lock the expected value after a mismatch.
module data_stream_checker #(
    parameter int unsigned                 DATA_WIDTH    = 16,
    parameter int unsigned                 COUNT_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]       INIT_VALUE    = '0,
    parameter logic [15:0]                 LFSR_SEED     = 16'hACE1,
    parameter bit                          STOP_ON_ERROR = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [7:0]             ready_rate,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   busy,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] rx_count,
    output logic [COUNT_WIDTH-1:0] err_count,
    output logic                   err_flag,
    output logic [DATA_WIDTH-1:0]  err_expect,
    output logic [DATA_WIDTH-1:0]  err_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
        return (&c) ? c : c + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]             state_q, state_d;
    logic                   s_ready_q, s_ready_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [DATA_WIDTH-1:0]  expect_val_q, expect_val_d;
    logic [COUNT_WIDTH-1:0] rx_count_q, rx_count_d;
    logic [COUNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                   err_flag_q, err_flag_d;
    logic [DATA_WIDTH-1:0]  err_expect_q, err_expect_d;
    logic [DATA_WIDTH-1:0]  err_data_q, err_data_d;

    logic xfer;
    logic mismatch;

    assign xfer     = s_valid && s_ready_q;
    assign mismatch = xfer && (s_data != expect_val_q);

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        expect_val_d = expect_val_q;
        rx_count_d   = rx_count_q;
        err_count_d  = err_count_q;
        err_flag_d   = err_flag_q;
        err_expect_d = err_expect_q;
        err_data_d   = err_data_q;

        case (state_q)
            ST_IDLE: if (enable) state_d = ST_RUN;
            ST_RUN: begin
                if (STOP_ON_ERROR && mismatch) state_d = ST_HALT;
                else if (!enable)              state_d = ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_RUN) lfsr_d = lfsr_step(lfsr_q);

        // A transfer is checked whatever the state does in the same cycle.
        if (xfer) begin
            rx_count_d = sat_inc(rx_count_q);
`ifdef DATA_STREAM_CHECKER_RESYNC_EN
            expect_val_d = mismatch ? s_data + 1'b1 : expect_val_q + 1'b1;
`else
            expect_val_d = expect_val_q + 1'b1;
`endif
            if (mismatch) begin
                err_count_d = sat_inc(err_count_q);
                err_flag_d  = 1'b1;
                if (!err_flag_q) begin
                    err_expect_d = expect_val_q;
                    err_data_d   = s_data;
                end
            end
        end

        if (clear) begin
            state_d      = ST_IDLE;
            lfsr_d       = SEED;
            expect_val_d = INIT_VALUE;
            rx_count_d   = '0;
            err_count_d  = '0;
            err_flag_d   = 1'b0;
            err_expect_d = '0;
            err_data_d   = '0;
        end

        s_ready_d = (state_d == ST_RUN) && ((ready_rate == 8'hFF) || (lfsr_q[7:0] < ready_rate));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            s_ready_q    <= 1'b0;
            lfsr_q       <= SEED;
            expect_val_q <= INIT_VALUE;
            rx_count_q   <= '0;
            err_count_q  <= '0;
            err_flag_q   <= 1'b0;
            err_expect_q <= '0;
            err_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            s_ready_q    <= s_ready_d;
            lfsr_q       <= lfsr_d;
            expect_val_q <= expect_val_d;
            rx_count_q   <= rx_count_d;
            err_count_q  <= err_count_d;
            err_flag_q   <= err_flag_d;
            err_expect_q <= err_expect_d;
            err_data_q   <= err_data_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign busy       = (state_q == ST_RUN);
    assign halted     = (state_q == ST_HALT);
    assign rx_count   = rx_count_q;
    assign err_count  = err_count_q;
    assign err_flag   = err_flag_q;
    assign err_expect = err_expect_q;
    assign err_data   = err_data_q;

endmodule

// File: doc/data_stream_checker.md
Name: data_stream_checker

Overview:
- Single-clock stream consumer and sequence checker; the reader end of a valid/ready data path.
- Sinks a valid/ready stream and applies programmable pseudo-random back-pressure.
- Checks each accepted word against an incrementing expected value and reports counts plus first-error capture.
- Attaches to the m-side of data_async / FIFO blocks on the FPGA, or stands alone in a bench as a synthesizable scoreboard.

Parameters:
- DATA_WIDTH, 16, stream data width.
- COUNT_WIDTH, 32, width of rx_count and err_count.
- INIT_VALUE, 0, expected value of the first word after reset/clear.
- LFSR_SEED, 16'hACE1, 16-bit LFSR seed; a zero value is replaced by 16'h0001.
- STOP_ON_ERROR, 0, 1 = enter HALT on the first mismatch.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous clear of all state.
- enable  input  1  run request.
- ready_rate  input  8  back-pressure level: 0 = never ready, 8'hFF = always ready.
- s_data  input  DATA_WIDTH  stream data.
- s_valid  input  1  stream valid.
- s_ready  output  1  stream ready (registered).
- busy  output  1  state == RUN.
- halted  output  1  state == HALT.
- rx_count  output  COUNT_WIDTH  accepted words.
- err_count  output  COUNT_WIDTH  mismatched words.
- err_flag  output  1  sticky: any mismatch seen.
- err_expect  output  DATA_WIDTH  expected value at the first mismatch.
- err_data  output  DATA_WIDTH  received value at the first mismatch.

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - All outputs are 0, state IDLE.
  - expect = INIT_VALUE, lfsr = LFSR_SEED.
- clear (synchronous):
  - Wins over every other event in that cycle.
  - Produces the same values as reset.
- Transfer: s_valid && s_ready at a posedge. This is the only event that updates expect, rx_count or the error state.
- State machine:
  - IDLE -> RUN when enable = 1.
  - RUN -> IDLE when enable = 0.
  - RUN -> HALT on a mismatching transfer when STOP_ON_ERROR = 1.
  - HALT exits only via clear or reset.
- s_ready is a registered output with one-cycle latency:
  - next s_ready = (next state == RUN) && (ready_rate == 8'hFF || lfsr[7:0] < ready_rate).
  - A word offered while s_ready = 1 is accepted even if enable dropped in the same cycle.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It advances once per clock only while the state is RUN.
- On each transfer:
  - rx_count increments.
  - If s_data != expect: err_count increments and err_flag <= 1.
  - If err_flag was 0 before that transfer, err_expect <= expect and err_data <= s_data. Later errors do not overwrite the capture.
  - expect <= expect + 1, modulo 2^DATA_WIDTH: 16'hFFFF wraps to 0 with no error.
- rx_count and err_count saturate at all-ones and never wrap.
- s_valid while s_ready = 0: ignored; no counters change.
- A transfer that occurs in the same cycle the state leaves RUN is still fully checked.

Optional Feature:
- Macro: DATA_STREAM_CHECKER_RESYNC_EN.
- Defined: after a mismatching transfer, expect <= s_data + 1. The checker re-locks to the incoming sequence, so one dropped or duplicated word counts as exactly one error.
- Not defined: expect <= expect + 1 always. A single dropped word then makes every later word mismatch.

Test Plan:
- ready_rate = 8'hFF, enable = 1, source sends 0..999 back-to-back -> s_ready high from the 2nd clock after enable, rx_count = 1000, err_count = 0, err_flag = 0.
- ready_rate = 8'h00, enable = 1, s_valid held high for 100 cycles -> s_ready stays 0, rx_count = 0.
- ready_rate = 8'h40, random s_valid, 5000 words sent -> rx_count = 5000, no errors; measured s_ready duty in RUN ≈ 25% ±5%.
- Source sends 0,1,2,4,5,6, STOP_ON_ERROR = 0:
  - without macro -> err_count = 3, err_expect = 3, err_data = 4;
  - with macro -> err_count = 1, same capture.
- STOP_ON_ERROR = 1, source sends 0,1,7,8 -> halted = 1, s_ready = 0 from the next cycle, rx_count = 3, err_count = 1; a clear pulse returns all outputs to 0 and expect to INIT_VALUE.
- INIT_VALUE = 16'hFFFE, source sends FFFE, FFFF, 0000, 0001 -> no error; then reset_n pulsed low mid-stream -> s_ready = 0 and counters = 0 immediately, without waiting for a clock edge.
